// File: rtl/hw_ctrl_seq.sv
// hw_ctrl_seq
// -----------
// Hardwired controller for the teaching CPU. It keeps its own beat timing
// (W1..Wn) and the st0 phase flag, and decodes the console switch mode and
// the instruction opcode into the datapath control strobes.
//
// Ports
//   t3                 system clock, all state changes on the rising edge
//   clr                synchronous active-low reset
//   swc, swb, swa      console mode select, mode = {swc,swb,swa}
//   ir                 opcode field, only the upper 4 bits are decoded
//   c, z               carry and zero flags from the datapath
//   step               (HW_CTRL_SINGLE_STEP_EN only) single-step request
//   w                  one-hot current beat, w[0] = W1
//   st0_o              phase flag
//   drw ... long_o     datapath strobes
//   s                  ALU function select
//   sel                register select {sel3,sel2,sel1,sel0}
//
// Optional feature
//   HW_CTRL_SINGLE_STEP_EN adds the step input. In run mode with st0=1 the
//   last beat of every instruction then stalls until a rising step is seen.

module hw_ctrl_seq #(
    parameter int IR_W      = 4,
    parameter int MAX_BEATS = 3,
    parameter int S_W       = 4
) (
    input  logic                 t3,
    input  logic                 clr,
    input  logic                 swc,
    input  logic                 swb,
    input  logic                 swa,
    input  logic [IR_W-1:0]      ir,
    input  logic                 c,
    input  logic                 z,
`ifdef HW_CTRL_SINGLE_STEP_EN
    input  logic                 step,
`endif
    output logic [MAX_BEATS-1:0] w,
    output logic                 st0_o,
    output logic                 drw,
    output logic                 pcinc,
    output logic                 lpc,
    output logic                 lar,
    output logic                 pcadd,
    output logic                 arinc,
    output logic                 selctl,
    output logic                 memw,
    output logic                 stop,
    output logic                 lir,
    output logic                 ldz,
    output logic                 ldc,
    output logic                 cin,
    output logic                 m,
    output logic                 abus,
    output logic                 sbus,
    output logic                 mbus,
    output logic                 short_o,
    output logic                 long_o,
    output logic [S_W-1:0]       s,
    output logic [3:0]           sel
);

    typedef enum logic [1:0] {
        BEAT_W1 = 2'd0,
        BEAT_W2 = 2'd1,
        BEAT_W3 = 2'd2,
        BEAT_W4 = 2'd3
    } beat_t;

    beat_t      r_beat;
    beat_t      w_nextBeat;
    logic       r_st0;
    logic       w_nextSt0;
    logic [2:0] r_swLatched;
    logic [2:0] w_sw;
    logic       w_modeChange;
    logic [3:0] w_opcode;
    logic       w_holdBeat;
    logic       w_idleMode;

    assign w_sw         = {swc, swb, swa};
    assign w_modeChange = (w_sw != r_swLatched);
    assign w_opcode     = ir[IR_W-1 -: 4];
    assign w_idleMode   = r_swLatched[2] && (r_swLatched[1:0] != 2'b00);
    assign st0_o        = r_st0;
    assign w            = MAX_BEATS'(1) << r_beat;

`ifdef HW_CTRL_SINGLE_STEP_EN
    logic r_stepPrev;
    logic w_stepRelease;

    // Step is level-sampled; only its rising edge releases a stalled
    // instruction, so holding step high runs exactly one instruction.
    assign w_stepRelease = step && !r_stepPrev;

    always_ff @(posedge t3) begin
        if (!clr) begin
            r_stepPrev <= 1'b0;
        end else begin
            r_stepPrev <= step;
        end
    end
`endif

    // State register. Reset wins over a mode change, which wins over the
    // normal beat/st0 update. A mode change restarts the new mode at W1 with
    // st0 cleared and latches the new switch setting.
    always_ff @(posedge t3) begin
        if (!clr) begin
            r_beat      <= BEAT_W1;
            r_st0       <= 1'b0;
            r_swLatched <= w_sw;
        end else if (w_modeChange) begin
            r_beat      <= BEAT_W1;
            r_st0       <= 1'b0;
            r_swLatched <= w_sw;
        end else begin
            r_beat      <= w_nextBeat;
            r_st0       <= w_nextSt0;
        end
    end

    // Strobe decode and next-state logic. Strobes stay at zero during reset
    // and during the cycle in which the switches differ from the latched mode.
    always_comb begin
        drw = 1'b0; pcinc = 1'b0; lpc = 1'b0; lar = 1'b0; pcadd = 1'b0;
        arinc = 1'b0; selctl = 1'b0; memw = 1'b0; stop = 1'b0; lir = 1'b0;
        ldz = 1'b0; ldc = 1'b0; cin = 1'b0; m = 1'b0; abus = 1'b0;
        sbus = 1'b0; mbus = 1'b0; short_o = 1'b0; long_o = 1'b0;
        s = '0;
        sel = 4'b0000;
        w_nextSt0 = r_st0;
        w_nextBeat = BEAT_W1;
        w_holdBeat = 1'b0;

        if (clr && !w_modeChange) begin
            case (r_swLatched)
                3'b000: begin
                    if (!r_st0) begin
                        if (r_beat == BEAT_W1) begin
                            sbus = 1'b1; lpc = 1'b1; short_o = 1'b1;
                            w_nextSt0 = 1'b1;
                        end
                    end else begin
                        case (r_beat)
                            BEAT_W1: begin
                                lir = 1'b1; pcinc = 1'b1;
                            end
                            BEAT_W2: begin
                                case (w_opcode)
                                    4'b0001: begin
                                        s = S_W'(4'b1001); cin = 1'b1; abus = 1'b1;
                                        drw = 1'b1; ldz = 1'b1; ldc = 1'b1;
                                    end
                                    4'b0010: begin
                                        s = S_W'(4'b0110); abus = 1'b1;
                                        drw = 1'b1; ldz = 1'b1; ldc = 1'b1;
                                    end
                                    4'b0011: begin
                                        s = S_W'(4'b1011); m = 1'b1; abus = 1'b1;
                                        drw = 1'b1; ldz = 1'b1;
                                    end
                                    4'b0100: begin
                                        s = S_W'(4'b0000); abus = 1'b1;
                                        drw = 1'b1; ldz = 1'b1; ldc = 1'b1;
                                    end
                                    4'b0101: begin
                                        s = S_W'(4'b1010); m = 1'b1; abus = 1'b1;
                                        lar = 1'b1; long_o = 1'b1;
                                    end
                                    4'b0110: begin
                                        s = S_W'(4'b1111); m = 1'b1; abus = 1'b1;
                                        lar = 1'b1; long_o = 1'b1;
                                    end
                                    4'b0111: pcadd = c;
                                    4'b1000: pcadd = z;
                                    4'b1001: begin
                                        s = S_W'(4'b1111); m = 1'b1; abus = 1'b1;
                                        lpc = 1'b1;
                                    end
                                    4'b1110: stop = 1'b1;
                                    default: ;
                                endcase
                            end
                            BEAT_W3: begin
                                if (w_opcode == 4'b0101) begin
                                    mbus = 1'b1; drw = 1'b1;
                                end else if (w_opcode == 4'b0110) begin
                                    s = S_W'(4'b1010); m = 1'b1; abus = 1'b1;
                                    memw = 1'b1;
                                end
                            end
                            default: ;
                        endcase
`ifdef HW_CTRL_SINGLE_STEP_EN
                        // The last beat of an instruction is any beat past W1
                        // that does not request a longer cycle.
                        if ((r_beat != BEAT_W1) && !long_o && !w_stepRelease) begin
                            stop = 1'b1;
                        end
`endif
                    end
                end
                3'b001: begin
                    if (r_beat == BEAT_W1) begin
                        sbus = 1'b1; stop = 1'b1; short_o = 1'b1; selctl = 1'b1;
                        if (!r_st0) begin
                            lar = 1'b1;
                            w_nextSt0 = 1'b1;
                        end else begin
                            memw = 1'b1; arinc = 1'b1;
                        end
                    end
                end
                3'b010: begin
                    if (r_beat == BEAT_W1) begin
                        stop = 1'b1; short_o = 1'b1; selctl = 1'b1;
                        if (!r_st0) begin
                            sbus = 1'b1; lar = 1'b1;
                            w_nextSt0 = 1'b1;
                        end else begin
                            mbus = 1'b1; arinc = 1'b1;
                        end
                    end
                end
                3'b011: begin
                    selctl = 1'b1; stop = 1'b1;
                    if (r_beat == BEAT_W1) begin
                        sel = 4'b0001;
                    end else if (r_beat == BEAT_W2) begin
                        sel = 4'b1011;
                    end
                end
                3'b100: begin
                    sbus = 1'b1; drw = 1'b1; selctl = 1'b1; stop = 1'b1;
                    if (r_beat == BEAT_W1) begin
                        sel = r_st0 ? 4'b1001 : 4'b0011;
                    end else if (r_beat == BEAT_W2) begin
                        sel = r_st0 ? 4'b1110 : 4'b0100;
                        w_nextSt0 = !r_st0;
                    end
                end
                default: ;
            endcase
        end

        // In the console modes stop is only the wait request to the external
        // clock gate: every t3 edge that arrives there is an operator release,
        // so the beat advances. In run mode stop freezes the beat internally.
        w_holdBeat = stop && (r_swLatched == 3'b000);

        if (w_idleMode) begin
            w_nextBeat = BEAT_W1;
        end else if (w_holdBeat) begin
            w_nextBeat = r_beat;
        end else begin
            case (r_beat)
                BEAT_W1: w_nextBeat = short_o ? BEAT_W1 : BEAT_W2;
                BEAT_W2: w_nextBeat = long_o ? BEAT_W3 : BEAT_W1;
                BEAT_W3: w_nextBeat = ((MAX_BEATS == 4) && long_o) ? BEAT_W4 : BEAT_W1;
                default: w_nextBeat = BEAT_W1;
            endcase
        end
    end

endmodule
